// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving the registered Common Data Bus
module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 7,
    parameter int DATA_W = 32,
    parameter int ROB_W  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    input  logic [NUM_FU*ROB_W-1:0]  fu_rob,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [ROB_W-1:0]         cdb_rob,
    output logic [31:0]              busy_cycles
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    // One extra bit so pointer+offset never overflows before the explicit wrap.
    localparam logic [PTR_W:0]   NUM_W = (PTR_W+1)'(NUM_FU);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_FU - 1);

    logic [TAG_W-1:0]  tag_arr  [NUM_FU];
    logic [DATA_W-1:0] data_arr [NUM_FU];
    logic [ROB_W-1:0]  rob_arr  [NUM_FU];

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [ROB_W-1:0]  cdb_rob_q, cdb_rob_d;
    logic [31:0]       busy_q, busy_d;

    logic              grant_any;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W:0]    sum;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_unpack
        assign tag_arr[i]  = fu_tag[i*TAG_W +: TAG_W];
        assign data_arr[i] = fu_data[i*DATA_W +: DATA_W];
        assign rob_arr[i]  = fu_rob[i*ROB_W +: ROB_W];
    end

    // Pick the first valid FU starting at rr_ptr; flush and reset suppress any grant.
    always_comb begin
        fu_ready  = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (sum >= NUM_W) begin
                sum = sum - NUM_W;
            end
            if (!grant_any && fu_valid[sum[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = sum[PTR_W-1:0];
            end
        end
        if (reset || flush) begin
            grant_any = 1'b0;
        end
        if (grant_any) begin
            fu_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state for pointer, broadcast register and saturating busy counter.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = grant_any;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_rob_d   = cdb_rob_q;
        busy_d      = busy_q;
        if (grant_any) begin
            rr_ptr_d   = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
            cdb_tag_d  = tag_arr[grant_idx];
            cdb_data_d = data_arr[grant_idx];
            cdb_rob_d  = rob_arr[grant_idx];
        end
        if (cdb_valid_q && (busy_q != 32'hFFFF_FFFF)) begin
            busy_d = busy_q + 32'd1;
        end
    end

    // State registers; reset clears everything including a broadcast in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_rob_q   <= '0;
            busy_q      <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_rob_q   <= cdb_rob_d;
            busy_q      <= busy_d;
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_tag     = cdb_tag_q;
    assign cdb_data    = cdb_data_q;
    assign cdb_rob     = cdb_rob_q;
    assign busy_cycles = busy_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter with a behavioural model
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 7;
    localparam int DW = 32;
    localparam int RW = 5;

    logic            clk;
    logic            reset;
    logic            flush;
    logic [N-1:0]    fu_valid;
    logic [N-1:0]    fu_ready;
    logic [N*TW-1:0] fu_tag;
    logic [N*DW-1:0] fu_data;
    logic [N*RW-1:0] fu_rob;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic [RW-1:0]   cdb_rob;
    logic [31:0]     busy_cycles;

    cdb_arbiter #(.NUM_FU(N), .TAG_W(TW), .DATA_W(DW), .ROB_W(RW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_tag(fu_tag), .fu_data(fu_data), .fu_rob(fu_rob),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_rob(cdb_rob), .busy_cycles(busy_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pending result held by each FU until accepted.
    logic          p_valid [N];
    logic [TW-1:0] p_tag   [N];
    logic [DW-1:0] p_data  [N];
    logic [RW-1:0] p_rob   [N];

    // Reference model state.
    int            m_ptr;
    logic          m_valid;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    logic [RW-1:0] m_rob;
    logic [31:0]   m_busy;

    int            checks = 0;
    int            fails  = 0;
    int            last_grant;
    logic [N-1:0]  got_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int i);
        p_valid[i] = 1'b1;
        p_tag[i]   = TW'($urandom);
        p_data[i]  = $urandom;
        p_rob[i]   = RW'($urandom);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
    endtask

    // One clock: drive, check the combinational grant, take the edge, check the CDB.
    task automatic step(input logic rst, input logic fl);
        int g;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        reset = rst;
        flush = fl;
        for (int i = 0; i < N; i++) begin
            fu_valid[i]             = p_valid[i];
            fu_tag[i*TW +: TW]      = p_tag[i];
            fu_data[i*DW +: DW]     = p_data[i];
            fu_rob[i*RW +: RW]      = p_rob[i];
        end
        #1;
        g = -1;
        if (!rst && !fl) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && p_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_ready = (g >= 0) ? N'(1 << g) : '0;
        got_ready = fu_ready;
        chk("fu_ready", fu_ready, exp_ready);
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_valid = 0; m_tag = 0; m_data = 0; m_rob = 0; m_busy = 0;
        end else begin
            if (m_valid && m_busy != 32'hFFFF_FFFF) m_busy = m_busy + 1;
            if (g >= 0) begin
                m_valid = 1'b1;
                m_tag   = p_tag[g];
                m_data  = p_data[g];
                m_rob   = p_rob[g];
                m_ptr   = (g + 1) % N;
                p_valid[g] = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
        last_grant = g;
        #1;
        chk("cdb_valid", cdb_valid, m_valid);
        chk("cdb_tag", cdb_tag, m_tag);
        chk("cdb_data", cdb_data, m_data);
        chk("cdb_rob", cdb_rob, m_rob);
        chk("busy_cycles", busy_cycles, m_busy);
        chk("rr_ptr", dut.rr_ptr_q, m_ptr);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        fu_valid = '0; fu_tag = '0; fu_data = '0; fu_rob = '0;
        m_ptr = 0; m_valid = 0; m_tag = 0; m_data = 0; m_rob = 0; m_busy = 0;
        for (int i = 0; i < N; i++) fill(i);

        // Reset with every FU requesting.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("reset_busy", busy_cycles, 64'd0);
        chk("reset_ptr", dut.rr_ptr_q, 64'd0);

        // Single requester FU2.
        clear_all();
        p_valid[2] = 1'b1; p_tag[2] = 7'h2A; p_data[2] = 32'hDEAD_BEEF; p_rob[2] = 5'h11;
        step(1'b0, 1'b0);
        chk("single_ready", got_ready, 64'h4);
        chk("single_tag", cdb_tag, 64'h2A);
        chk("single_data", cdb_data, 64'hDEAD_BEEF);
        step(1'b0, 1'b0);
        chk("idle_valid", cdb_valid, 64'd0);

        // Round robin from pointer 0 with all FUs held valid.
        step(1'b1, 1'b0);
        clear_all();
        for (int c = 0; c < N; c++) begin
            for (int i = 0; i < N; i++) if (!p_valid[i]) fill(i);
            step(1'b0, 1'b0);
            chk("rr_order", last_grant, c);
            chk("rr_bcast", cdb_valid, 64'd1);
        end
        clear_all();
        step(1'b0, 1'b0);
        chk("rr_busy4", busy_cycles, 64'd4);

        // Fairness wrap: FU2 granted, then 0101 gives FU0 then FU2.
        fill(2);
        step(1'b0, 1'b0);
        chk("fair_first", last_grant, 64'd2);
        fill(0); fill(2);
        step(1'b0, 1'b0);
        chk("fair_wrap", last_grant, 64'd0);
        step(1'b0, 1'b0);
        chk("fair_next", last_grant, 64'd2);

        // Flush while FU1 is valid.
        clear_all();
        fill(1);
        step(1'b0, 1'b1);
        chk("flush_ready", got_ready, 64'd0);
        chk("flush_valid", cdb_valid, 64'd0);
        step(1'b0, 1'b0);
        chk("flush_after", last_grant, 64'd1);

        // Saturation of the busy counter.
        clear_all();
        step(1'b0, 1'b0);
        @(negedge clk);
        force dut.busy_q = 32'hFFFF_FFFE;
        #1;
        release dut.busy_q;
        m_busy = 32'hFFFF_FFFE;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) if (!p_valid[i]) fill(i);
            step(1'b0, 1'b0);
        end
        clear_all();
        step(1'b0, 1'b0);
        chk("busy_sat", busy_cycles, 64'hFFFF_FFFF);

        // Randomised traffic with occasional flush and reset.
        step(1'b1, 1'b0);
        for (int c = 0; c < 400; c++) begin
            logic rs, fl;
            for (int i = 0; i < N; i++) if (!p_valid[i] && ($urandom_range(0, 2) != 0)) fill(i);
            rs = ($urandom_range(0, 63) == 0);
            fl = ($urandom_range(0, 15) == 0);
            step(rs, fl);
            if (fl) for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 0) p_valid[i] = 1'b0;
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
